// File: rtl/wbc_arb2.sv
// Two-master round-robin Wishbone arbiter in front of a single classic-cycle slave.
// Ownership is held for the full cyc burst; a watchdog answers stalled strobes.
module wbc_arb2 #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int TMO = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    output logic [DW-1:0]     m0_dat_o,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    output logic              m0_ack_o,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    output logic [DW-1:0]     m1_dat_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    output logic              m1_ack_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    input  logic [DW-1:0]     s_dat_i,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [DW/8-1:0]   s_sel_o,
    input  logic              s_ack_i,
    output logic              tmo_o
);

    localparam int SW = DW / 8;
    localparam int WW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [WW-1:0] TMO_V = WW'(TMO);
    localparam logic          WD_EN = (TMO > 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic [WW-1:0] wdog_q, wdog_d;

    logic [1:0] cyc_v, stb_v, own_v, ack_v;
    logic       own_any, sel_m1, own_cyc, own_stb, wdog_hit;

    assign cyc_v   = {m1_cyc_i, m0_cyc_i};
    assign stb_v   = {m1_stb_i, m0_stb_i};
    assign own_v   = {state_q == ST_OWN1, state_q == ST_OWN0};
    assign own_any = |own_v;
    assign sel_m1  = own_v[1];
    assign own_cyc = |(own_v & cyc_v);
    assign own_stb = |(own_v & stb_v);

    // Slave side: everything is zero unless a master owns the bus.
    assign s_cyc_o = own_cyc;
    assign s_stb_o = own_cyc & own_stb;
    assign s_adr_o = own_any ? (sel_m1 ? m1_adr_i : m0_adr_i) : '0;
    assign s_dat_o = own_any ? (sel_m1 ? m1_dat_i : m0_dat_i) : '0;
    assign s_we_o  = own_any & (sel_m1 ? m1_we_i : m0_we_i);
    assign s_sel_o = own_any ? (sel_m1 ? m1_sel_i : m0_sel_i) : {SW{1'b0}};

    // A genuine ack in the same cycle takes precedence over a timeout.
    assign wdog_hit = WD_EN & s_stb_o & ~s_ack_i & (wdog_q == TMO_V);
    assign tmo_o    = wdog_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_v[gi] = own_v[gi] & cyc_v[gi] & (s_ack_i | wdog_hit);
        end
    endgenerate

    assign m0_ack_o = ack_v[0];
    assign m1_ack_o = ack_v[1];
    assign m0_dat_o = wdog_hit ? '0 : s_dat_i;
    assign m1_dat_o = wdog_hit ? '0 : s_dat_i;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    state_d = ST_OWN0;
                end else if (m1_cyc_i) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc_i ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? ST_OWN0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall counter: clears whenever the owner is answered or lets go.
    always_comb begin
        wdog_d = wdog_q;
        if (!WD_EN || !own_cyc || s_ack_i || wdog_hit) begin
            wdog_d = '0;
        end else if (s_stb_o && (wdog_q != TMO_V)) begin
            wdog_d = wdog_q + WW'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_wbc_arb2.sv
// Directed bench for wbc_arb2: grant latency, alternation, burst hold,
// slow read, watchdog timeout and mid-cycle reset.
module tb_wbc_arb2;

    logic        clk;
    logic        rst;
    logic [15:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o;
    logic [1:0]  m0_sel_i;
    logic [15:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o;
    logic [1:0]  m1_sel_i;
    logic [15:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, tmo_o;
    logic [1:0]  s_sel_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:15];

    wbc_arb2 #(.AW(16), .DW(16), .TMO(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_we_i  (m0_we_i),
        .m0_sel_i (m0_sel_i),
        .m0_ack_o (m0_ack_o),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_dat_o (m1_dat_o),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_we_i  (m1_we_i),
        .m1_sel_i (m1_sel_i),
        .m1_ack_o (m1_ack_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_ack_i  (s_ack_i),
        .tmo_o    (tmo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang, required finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = '0;
        m1_adr_i = '0; m1_dat_i = '0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = '0;
        s_dat_i = '0; s_ack_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h00FF; m0_sel_i = 2'b11;
        s_ack_i = 1; s_dat_i = 16'hBEEF;
        #4;
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o} !== 5'b0) begin
            errors++; $display("FAIL rst_ctrl: got %b required 00000", {s_cyc_o, s_stb_o, s_we_o, s_sel_o});
        end
        checks++;
        if (s_adr_o !== 16'h0 || s_dat_o !== 16'h0) begin
            errors++; $display("FAIL rst_adr_dat: got %h/%h required 0000/0000", s_adr_o, s_dat_o);
        end
        checks++;
        if ({m0_ack_o, m1_ack_o, tmo_o} !== 3'b0) begin
            errors++; $display("FAIL rst_acks: got %b required 000", {m0_ack_o, m1_ack_o, tmo_o});
        end
        checks++;
        if (m0_dat_o !== 16'hBEEF || m1_dat_o !== 16'hBEEF) begin
            errors++; $display("FAIL rst_dat_copy: got %h/%h required beef/beef", m0_dat_o, m1_dat_o);
        end
        clear_inputs();
        rst = 0;
        tick();
    endtask

    task automatic test_write_m0();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 16'h0100; m0_dat_i = 16'h1234; m0_sel_i = 2'b11;
        #4;
        checks++;
        if (s_cyc_o !== 1'b0) begin
            errors++; $display("FAIL wr_latency: s_cyc_o got %b required 0", s_cyc_o);
        end
        tick();
        s_ack_i = 1;
        #4;
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o} !== 5'b11111) begin
            errors++; $display("FAIL wr_ctrl: got %b required 11111", {s_cyc_o, s_stb_o, s_we_o, s_sel_o});
        end
        checks++;
        if (s_adr_o !== 16'h0100 || s_dat_o !== 16'h1234) begin
            errors++; $display("FAIL wr_adr_dat: got %h/%h required 0100/1234", s_adr_o, s_dat_o);
        end
        checks++;
        if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            errors++; $display("FAIL wr_ack: got m0=%b m1=%b required m0=1 m1=0", m0_ack_o, m1_ack_o);
        end
        tick();
        clear_inputs();
        #4;
        checks++;
        if (s_cyc_o !== 1'b0 || m0_ack_o !== 1'b0) begin
            errors++; $display("FAIL wr_release: got cyc=%b ack=%b required 0/0", s_cyc_o, m0_ack_o);
        end
        tick();
        $display("write m0 adr=0100 dat=1234 done");
    endtask

    task automatic test_alternation();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0010;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 16'h0020;
        tick();
        s_ack_i = 1;
        #4;
        checks++;
        if (s_adr_o !== 16'h0010 || m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            errors++; $display("FAIL alt_first: got adr=%h m0=%b m1=%b required 0010/1/0", s_adr_o, m0_ack_o, m1_ack_o);
        end
        tick();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        #4;
        checks++;
        if (s_cyc_o !== 1'b0) begin
            errors++; $display("FAIL alt_drop: s_cyc_o got %b required 0", s_cyc_o);
        end
        tick();
        s_ack_i = 1;
        #4;
        checks++;
        if (s_adr_o !== 16'h0020 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
            errors++; $display("FAIL alt_handover: got adr=%h m1=%b m0=%b required 0020/1/0", s_adr_o, m1_ack_o, m0_ack_o);
        end
        tick();
        clear_inputs();
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0010;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 16'h0020;
        tick();
        #4;
        checks++;
        if (s_adr_o !== 16'h0010 || s_cyc_o !== 1'b1) begin
            errors++; $display("FAIL alt_second_tie: got adr=%h cyc=%b required 0010/1", s_adr_o, s_cyc_o);
        end
        clear_inputs();
        tick();
        tick();
        $display("alternation m0 -> m1 -> m0 done");
    endtask

    task automatic test_burst_m1();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 16'h0200;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0300;
        for (int i = 0; i < 4; i++) begin
            m1_adr_i = 16'h0200 + 16'(i);
            s_ack_i = 1;
            s_dat_i = 16'hA000 + 16'(i);
            #4;
            checks++;
            if (s_adr_o !== 16'h0200 + 16'(i) || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 ||
                m1_dat_o !== 16'hA000 + 16'(i)) begin
                errors++; $display("FAIL burst_beat%0d: got adr=%h m1=%b m0=%b dat=%h required %h/1/0/%h",
                                   i, s_adr_o, m1_ack_o, m0_ack_o, m1_dat_o, 16'h0200 + 16'(i), 16'hA000 + 16'(i));
            end
            $display("burst beat %0d adr=%h dat=%h", i, s_adr_o, m1_dat_o);
            tick();
        end
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        tick();
        #4;
        checks++;
        if (s_adr_o !== 16'h0300 || s_cyc_o !== 1'b1) begin
            errors++; $display("FAIL burst_m0_grant: got adr=%h cyc=%b required 0300/1", s_adr_o, s_cyc_o);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_mem_read_m1();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 16'h0005;
        tick();
        #4;
        checks++;
        if (m1_ack_o !== 1'b0 || m0_ack_o !== 1'b0) begin
            errors++; $display("FAIL rd_wait: got m1=%b m0=%b required 0/0", m1_ack_o, m0_ack_o);
        end
        tick();
        s_ack_i = 1;
        s_dat_i = mem[s_adr_o[3:0]];
        #4;
        checks++;
        if (m1_ack_o !== 1'b1 || m1_dat_o !== 16'h5A5A || m0_ack_o !== 1'b0) begin
            errors++; $display("FAIL rd_data: got ack=%b dat=%h m0=%b required 1/5a5a/0", m1_ack_o, m1_dat_o, m0_ack_o);
        end
        $display("mem read m1 adr=0005 dat=%h", m1_dat_o);
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_watchdog();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h7FFF; s_dat_i = 16'h1111;
        tick();
        for (int k = 1; k <= 8; k++) begin
            #4;
            checks++;
            if (m0_ack_o !== 1'b0 || tmo_o !== 1'b0) begin
                errors++; $display("FAIL wd_early%0d: got ack=%b tmo=%b required 0/0", k, m0_ack_o, tmo_o);
            end
            tick();
        end
        #4;
        checks++;
        if (m0_ack_o !== 1'b1 || tmo_o !== 1'b1 || m0_dat_o !== 16'h0 || m1_ack_o !== 1'b0) begin
            errors++; $display("FAIL wd_fire: got ack=%b tmo=%b dat=%h m1=%b required 1/1/0000/0",
                               m0_ack_o, tmo_o, m0_dat_o, m1_ack_o);
        end
        tick();
        #4;
        checks++;
        if (tmo_o !== 1'b0 || m0_ack_o !== 1'b0) begin
            errors++; $display("FAIL wd_pulse: got tmo=%b ack=%b required 0/0", tmo_o, m0_ack_o);
        end
        clear_inputs();
        tick();
        #4;
        checks++;
        if (s_cyc_o !== 1'b0 || s_adr_o !== 16'h0) begin
            errors++; $display("FAIL wd_idle: got cyc=%b adr=%h required 0/0000", s_cyc_o, s_adr_o);
        end
        tick();
        $display("watchdog timeout on stb cycle 9 done");
    endtask

    task automatic test_reset_mid();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 16'h0042;
        tick();
        #4;
        checks++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 16'h0042) begin
            errors++; $display("FAIL mr_own1: got cyc=%b adr=%h required 1/0042", s_cyc_o, s_adr_o);
        end
        rst = 1;
        tick();
        s_ack_i = 1;
        #4;
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o} !== 5'b0 || s_adr_o !== 16'h0 ||
            {m0_ack_o, m1_ack_o, tmo_o} !== 3'b0) begin
            errors++; $display("FAIL mr_outputs: got ctrl=%b adr=%h acks=%b required 0/0000/000",
                               {s_cyc_o, s_stb_o, s_we_o, s_sel_o}, s_adr_o, {m0_ack_o, m1_ack_o, tmo_o});
        end
        rst = 0;
        clear_inputs();
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0A0A;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 16'h0B0B;
        tick();
        #4;
        checks++;
        if (s_adr_o !== 16'h0A0A) begin
            errors++; $display("FAIL mr_tie: s_adr_o got %h required 0a0a", s_adr_o);
        end
        clear_inputs();
        tick();
        tick();
        $display("mid-cycle reset done");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'hC000 + 16'(i);
        mem[5] = 16'h5A5A;
        rst = 1;
        clear_inputs();
        test_reset();
        test_write_m0();
        test_alternation();
        test_burst_m1();
        test_mem_read_m1();
        test_watchdog();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
